fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Instruction fetch stage downstream of the PC unit. Each cycle it may issue the current PC
//   to instruction memory, captures the returned word one cycle later, and buffers {pc, instr}
//   pairs in a DEPTH-entry FIFO. It presents up to two instructions per cycle to dual-issue
//   decode. Back-pressure to the PC unit is pc_stall. Branch redirects use flush.
// PARAMETERS
//   DEPTH  8   FIFO entries; power of 2, >= 4
//   XLEN   32  PC width
//   ILEN   32  instruction width
// PORTS
//   clk         in   1      clock. Single clock domain.
//   reset       in   1      synchronous, active-high reset
//   pc          in   XLEN   current PC from the PC unit
//   pc_stall    out  1      1 = PC unit holds PC. A redirect has priority over pc_stall.
//   imem_req    out  1      fetch request this cycle
//   imem_addr   out  XLEN   = pc. Combinational.
//   imem_rdata  in   ILEN   instruction word. Valid exactly 1 cycle after imem_req.
//   flush       in   1      redirect/squash. Clears the queue and any in-flight fetch.
//   out0_valid  out  1      slot 0 (oldest entry) valid
//   out0_pc     out  XLEN   slot 0 PC
//   out0_instr  out  ILEN   slot 0 instruction
//   out1_valid  out  1      slot 1 (second-oldest entry) valid
//   out1_pc     out  XLEN   slot 1 PC
//   out1_instr  out  ILEN   slot 1 instruction
//   dec_take    in   2      decode consumption: 00 none, 01 slot0, 11 both, 10 illegal (no pop)
//   count       out  clog2(DEPTH)+1   current occupancy
// BEHAVIOUR
//   - State registers: head, tail (clog2(DEPTH) bits, wrap modulo DEPTH); count; inflight (1b); req_pc.
//     Entry storage is not reset.
//   - Reset, or flush at any cycle:
//       next cycle head=tail=count=0 and inflight=0; out0_valid=out1_valid=0.
//       While reset or flush is asserted: imem_req=0 and pc_stall=1.
//       Flush beats a same-cycle enqueue and dequeue. A response arriving in the flush cycle is dropped.
//   - Request rule: imem_req = !reset && !flush && (count + inflight < DEPTH).
//       The check is conservative: it ignores this cycle's dequeue.
//       pc_stall = !imem_req. imem_addr = pc always.
//   - On imem_req: inflight<=1 and req_pc<=pc. Otherwise inflight<=0.
//   - Enqueue: when inflight && !flush, write {req_pc, imem_rdata} at tail and advance tail by 1.
//   - Outputs are registered-state reads with no bypass:
//       out0 = entry[head],   out0_valid = (count>=1)
//       out1 = entry[head+1], out1_valid = (count>=2)
//     Latency: req in cycle t, data in cycle t+1, out0_valid in cycle t+2.
//   - Dequeue count deq:
//       01 -> out0_valid ? 1 : 0
//       11 -> out0_valid + out1_valid (a take of an invalid slot is ignored)
//       00, 10 -> 0
//     head advances by deq.
//   - count_next = count + enq - deq. Simultaneous enqueue and dequeue are legal, including when count=0 or count=DEPTH.
//   - Overflow is impossible by the credit rule; an assertion checks count+inflight <= DEPTH.
//   - When valid=0, pc/instr outputs carry stale entry contents and are not checked.
//   - Order is strict FIFO. Slot 0 is always older than slot 1.
// TESTING
//   T1 Check latency and steady-state throughput.
//      Stimulus: reset 2 cycles, then pc steps 0,4,8,... whenever !pc_stall; dec_take=11.
//      Required: out0_pc=0 two cycles after the first req. Steady state has imem_req=1 every cycle and count <= 1.
//   T2 Check fill and back-pressure.
//      Stimulus: dec_take=00.
//      Required: after 8 requests count=8 and pc_stall=1; imem_req stays 0; out0_pc=0 and out1_pc=4.
//   T3 Check credit release from full.
//      Stimulus: start from T2's full state, pulse dec_take=01 for one cycle.
//      Required: count=7. Then exactly one req, and the next cycle count=8 with the new entry at tail.
//   T4 Check flush with a fetch in flight.
//      Stimulus: count=5 and inflight=1, assert flush with pc=0x100 on the following cycle.
//      Required: next cycle count=0, valids 0, stale response dropped; the first entry after that is pc=0x100.
//   T5 Check partial and illegal takes.
//      Stimulus: count=1 with dec_take=11; then count=3 with dec_take=10.
//      Required: the first pops 1 (count 0); the second pops none (count 3).
//   T6 Check wrap-around and reset mid-stream against a reference model.
//      Stimulus: random dec_take over 3*DEPTH fetches, reset asserted mid-stream.
//      Required: in-order {pc, instr} match across pointer wrap; all state is 0 the cycle after reset.

Source files
------------

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch stage sitting between the PC unit and dual-issue decode.
//   Each cycle it may issue the current PC to instruction memory, captures the
//   returned word one cycle later and buffers {pc, instr} pairs in a DEPTH-entry
//   FIFO. The two oldest entries are presented to decode every cycle.
//
// Ports
//   clk, reset              single clock, synchronous active-high reset
//   pc                      current PC from the PC unit
//   pc_stall                1 = PC unit must hold its PC
//   imem_req / imem_addr    fetch request and address (imem_addr = pc)
//   imem_rdata              instruction word, valid one cycle after imem_req
//   flush                   redirect: drops the queue and any in-flight fetch
//   out0_* / out1_*         oldest / second-oldest entry and their valids
//   dec_take                00 none, 01 slot0, 11 both, 10 ignored
//   count                   current occupancy
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [XLEN-1:0]          pc,
    output logic                     pc_stall,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [ILEN-1:0]          imem_rdata,
    input  logic                     flush,
    output logic                     out0_valid,
    output logic [XLEN-1:0]          out0_pc,
    output logic [ILEN-1:0]          out0_instr,
    output logic                     out1_valid,
    output logic [XLEN-1:0]          out1_pc,
    output logic [ILEN-1:0]          out1_instr,
    input  logic [1:0]               dec_take,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    // Pointers and bookkeeping
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW-1:0]   head_p1;
    logic            inflight;
    logic [XLEN-1:0] req_pc;

    // Entry storage; contents are don't-care until written, so no reset.
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];

    logic            enq;
    logic [1:0]      deq;
    logic [AW+1:0]   used;

    // ------------------------------------------------------------------
    // Credit check: an entry slot is reserved for every in-flight fetch,
    // so a returning word always has room. This cycle's dequeue is not
    // counted, which keeps the request path off the decode timing path.
    // ------------------------------------------------------------------
    assign used      = {1'b0, count} + (AW+2)'(inflight);
    assign imem_req  = !reset && !flush && (used < (AW+2)'(DEPTH));
    assign pc_stall  = !imem_req;
    assign imem_addr = pc;

    // A response landing in a flush or reset cycle is squashed.
    assign enq = inflight && !flush && !reset;

    // ------------------------------------------------------------------
    // Output slots: plain reads of registered state, no bypass from the
    // incoming response.
    // ------------------------------------------------------------------
    assign head_p1    = head + AW'(1);
    assign out0_valid = (count >= (AW+1)'(1));
    assign out1_valid = (count >= (AW+1)'(2));
    assign out0_pc    = pc_mem[head];
    assign out0_instr = instr_mem[head];
    assign out1_pc    = pc_mem[head_p1];
    assign out1_instr = instr_mem[head_p1];

    // Taking an invalid slot is silently ignored; 10 never pops.
    always_comb begin
        deq = 2'd0;
        case (dec_take)
            2'b01:   deq = {1'b0, out0_valid};
            2'b11:   deq = {1'b0, out0_valid} + {1'b0, out1_valid};
            default: deq = 2'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            req_pc   <= '0;
        end else begin
            assert (used <= (AW+2)'(DEPTH));
            inflight <= imem_req;
            if (imem_req) begin
                req_pc <= pc;
            end
            if (enq) begin
                tail <= tail + AW'(1);
            end
            head  <= head + AW'(deq);
            count <= count + (AW+1)'(enq) - (AW+1)'(deq);
        end
    end

    // ------------------------------------------------------------------
    // Entry storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail]    <= req_pc;
            instr_mem[tail] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//   Directed bench for fetch_queue. The bench plays the PC unit (advance by 4
//   when not stalled) and a one-cycle instruction memory whose word for
//   address a is {a[15:0], ~a[15:0]}. A small queue model tracks the expected
//   FIFO contents every cycle alongside the hand-computed directed checks.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        out0_valid;
    logic [31:0] out0_pc;
    logic [31:0] out0_instr;
    logic        out1_valid;
    logic [31:0] out1_pc;
    logic [31:0] out1_instr;
    logic [1:0]  dec_take;
    logic [3:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_queue #(.DEPTH(8), .XLEN(32), .ILEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .pc_stall   (pc_stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .out0_valid (out0_valid),
        .out0_pc    (out0_pc),
        .out0_instr (out0_instr),
        .out1_valid (out1_valid),
        .out1_pc    (out1_pc),
        .out1_instr (out1_instr),
        .dec_take   (dec_take),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference queue model
    logic [63:0] q[$];
    logic        m_infl = 1'b0;
    logic [63:0] m_pend;
    bit          model_on = 1'b0;

    // One clock: sample this cycle's inputs/outputs, take the edge, then
    // update the PC unit, memory response and model, and compare.
    task automatic tick();
        logic        s_req, s_rst, s_fl, adv;
        logic [31:0] s_pc;
        logic [1:0]  s_take;
        int          d;
        #1;
        s_req  = imem_req;
        s_pc   = pc;
        s_take = dec_take;
        s_rst  = reset;
        s_fl   = flush;
        adv    = !pc_stall;
        @(posedge clk);
        #1;
        imem_rdata = s_req ? f(s_pc) : 32'hBAD0_BAD0;
        if (adv) pc = pc + 32'd4;
        if (s_rst) model_on = 1'b1;
        if (s_rst || s_fl) begin
            q.delete();
            m_infl = 1'b0;
        end else begin
            d = 0;
            if (s_take == 2'b01) d = (q.size() >= 1) ? 1 : 0;
            if (s_take == 2'b11) d = (q.size() >= 2) ? 2 : q.size();
            for (int i = 0; i < d; i++) void'(q.pop_front());
            if (m_infl) q.push_back(m_pend);
            m_infl = s_req;
            m_pend = {s_pc, f(s_pc)};
        end
        if (model_on) begin
            chk("m_count", 64'(count), 64'(q.size()));
            chk("m_v0", 64'(out0_valid), 64'(q.size() >= 1));
            chk("m_v1", 64'(out1_valid), 64'(q.size() >= 2));
            if (q.size() >= 1) chk("m_slot0", {out0_pc, out0_instr}, q[0]);
            if (q.size() >= 2) chk("m_slot1", {out1_pc, out1_instr}, q[1]);
        end
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        pc         = 32'd0;
        imem_rdata = 32'd0;
        dec_take   = 2'b11;

        // ---------------- T1: latency and throughput ----------------
        #1;
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_stall", 64'(pc_stall), 64'd1);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_v0", 64'(out0_valid), 64'd0);
        chk("rst_v1", 64'(out1_valid), 64'd0);
        #1;
        chk("t1_req0", 64'(imem_req), 64'd1);
        chk("t1_addr0", 64'(imem_addr), 64'd0);
        tick();
        tick();
        chk("t1_v0", 64'(out0_valid), 64'd1);
        chk("t1_pc0", 64'(out0_pc), 64'd0);
        chk("t1_instr0", 64'(out0_instr), 64'h0000_FFFF);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t1_req_ss", 64'(imem_req), 64'd1);
            chk("t1_count_le1", 64'(count <= 4'd1), 64'd1);
        end

        // ---------------- T2: fill and back-pressure ----------------
        reset    = 1'b1;
        pc       = 32'd0;
        dec_take = 2'b00;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20 && count !== 4'd8; i++) tick();
        chk("t2_count", 64'(count), 64'd8);
        chk("t2_stall", 64'(pc_stall), 64'd1);
        chk("t2_req", 64'(imem_req), 64'd0);
        chk("t2_pc0", 64'(out0_pc), 64'd0);
        chk("t2_pc1", 64'(out1_pc), 64'd4);
        chk("t2_instr1", 64'(out1_instr), 64'h0004_FFFB);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_req_hold", 64'(imem_req), 64'd0);
        end
        chk("t2_pc_held", 64'(pc), 64'd32);

        // ---------------- T3: credit release from full ----------------
        dec_take = 2'b01;
        #1;
        chk("t3_req_full", 64'(imem_req), 64'd0);
        tick();
        dec_take = 2'b00;
        chk("t3_count7", 64'(count), 64'd7);
        #1;
        chk("t3_req_one", 64'(imem_req), 64'd1);
        chk("t3_addr", 64'(imem_addr), 64'd32);
        tick();
        chk("t3_req_none", 64'(imem_req), 64'd0);
        chk("t3_count7b", 64'(count), 64'd7);
        tick();
        chk("t3_count8", 64'(count), 64'd8);
        chk("t3_pc0", 64'(out0_pc), 64'd4);
        dec_take = 2'b11;
        tick();
        tick();
        tick();
        chk("t3_count3", 64'(count), 64'd3);
        chk("t3_pc0_drain", 64'(out0_pc), 64'd28);
        chk("t3_tail_pc", 64'(out1_pc), 64'd32);
        chk("t3_tail_instr", 64'(out1_instr), 64'h0020_FFDF);

        // ---------------- T4: flush with fetch in flight ----------------
        reset    = 1'b1;
        pc       = 32'd0;
        dec_take = 2'b00;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20 && count !== 4'd5; i++) tick();
        chk("t4_count5", 64'(count), 64'd5);
        flush = 1'b1;
        #1;
        chk("t4_req_fl", 64'(imem_req), 64'd0);
        chk("t4_stall_fl", 64'(pc_stall), 64'd1);
        tick();
        flush = 1'b0;
        pc    = 32'h100;
        chk("t4_count0", 64'(count), 64'd0);
        chk("t4_v0", 64'(out0_valid), 64'd0);
        chk("t4_v1", 64'(out1_valid), 64'd0);
        #1;
        chk("t4_req", 64'(imem_req), 64'd1);
        chk("t4_addr", 64'(imem_addr), 64'h100);
        tick();
        tick();
        chk("t4_count1", 64'(count), 64'd1);
        chk("t4_pc0", 64'(out0_pc), 64'h100);
        chk("t4_instr0", 64'(out0_instr), 64'h0100_FEFF);

        // ---------------- T5: partial and illegal takes ----------------
        // Slot 1 is empty: 11 pops only slot 0; the concurrent fetch refills.
        dec_take = 2'b11;
        tick();
        chk("t5_count_partial", 64'(count), 64'd1);
        chk("t5_pc0_partial", 64'(out0_pc), 64'h104);
        dec_take = 2'b00;
        for (int i = 0; i < 10 && count !== 4'd3; i++) tick();
        chk("t5_count3", 64'(count), 64'd3);
        dec_take = 2'b10;
        tick();
        chk("t5_count_illegal", 64'(count), 64'd4);
        chk("t5_pc0_illegal", 64'(out0_pc), 64'h104);
        chk("t5_pc1_illegal", 64'(out1_pc), 64'h108);

        // ---------------- T6: random takes, wrap, reset mid-stream ----------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 48; i++) begin
            dec_take = 2'($urandom_range(0, 3));
            tick();
        end
        reset    = 1'b1;
        dec_take = 2'b11;
        tick();
        reset = 1'b0;
        chk("t6_rst_count", 64'(count), 64'd0);
        chk("t6_rst_v0", 64'(out0_valid), 64'd0);
        chk("t6_rst_v1", 64'(out1_valid), 64'd0);
        for (int i = 0; i < 48; i++) begin
            dec_take = 2'($urandom_range(0, 3));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
